// File: rtl/mem_access_unit_if.sv
// Request/response handshakes and DataMemory port of the load/store initiator.
// master = the access unit, slave = the pipeline/memory environment.
interface mem_access_unit_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_rw;
    logic [1:0]        req_size;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              resp_valid;
    logic              resp_ready;
    logic [31:0]       resp_rdata;
    logic              resp_err;

    logic [ADDR_W-1:0] mem_A;
    logic [31:0]       mem_DI;
    logic [31:0]       mem_DO;
    logic [1:0]        mem_Size;
    logic              mem_RW;
    logic              mem_E;

    modport master (
        input  req_valid, req_rw, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_A, mem_DI, mem_Size, mem_RW, mem_E,
        input  mem_DO
    );

    modport slave (
        output req_valid, req_rw, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_A, mem_DI, mem_Size, mem_RW, mem_E,
        output mem_DO
    );
endinterface

// File: rtl/mem_access_unit.sv
// Single-outstanding load/store initiator for DataMemory: alignment check,
// optional wait states, load extension, one response per request.
module mem_access_unit #(
    parameter int WAIT_CYCLES = 0,
    parameter int ADDR_W      = 8
) (
    input  logic               clk,
    input  logic               reset,
    mem_access_unit_if.master  bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [3:0]        r_cnt;
    logic              r_rw;
    logic              r_signed;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_rdata;
    logic              r_err;

    logic              w_misaligned;
    logic              w_accept;
    logic              w_done;
    logic [31:0]       w_wdata_masked;
    logic [31:0]       w_load_ext;

    always_comb begin
        w_misaligned = 1'b0;
        case (bus.req_size)
            2'b01:   w_misaligned = bus.req_addr[0];
            2'b10:   w_misaligned = |bus.req_addr[1:0];
            2'b11:   w_misaligned = 1'b1;
            default: w_misaligned = 1'b0;
        endcase
    end

    always_comb begin
        w_wdata_masked = bus.req_wdata;
        case (bus.req_size)
            2'b00:   w_wdata_masked = {24'b0, bus.req_wdata[7:0]};
            2'b01:   w_wdata_masked = {16'b0, bus.req_wdata[15:0]};
            default: w_wdata_masked = bus.req_wdata;
        endcase
    end

    // DO arrives right-justified and zero-filled, so only the sign fill is added here
    always_comb begin
        w_load_ext = bus.mem_DO;
        case (r_size)
            2'b00:   w_load_ext = {{24{r_signed & bus.mem_DO[7]}}, bus.mem_DO[7:0]};
            2'b01:   w_load_ext = {{16{r_signed & bus.mem_DO[15]}}, bus.mem_DO[15:0]};
            default: w_load_ext = bus.mem_DO;
        endcase
    end

    assign w_accept = (r_state == IDLE) && bus.req_valid;
    assign w_done   = (r_state == ACCESS) && (r_cnt == 4'd0);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_state_next = w_misaligned ? RESP : ACCESS;
            ACCESS:  if (r_cnt == 4'd0) w_state_next = RESP;
            RESP:    if (bus.resp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt    <= 4'd0;
            r_rw     <= 1'b0;
            r_signed <= 1'b0;
            r_size   <= 2'b00;
            r_addr   <= '0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_cnt    <= 4'(WAIT_CYCLES);
            r_rw     <= bus.req_rw;
            r_signed <= bus.req_signed;
            r_size   <= bus.req_size;
            r_addr   <= bus.req_addr;
            r_wdata  <= w_wdata_masked;
            r_rdata  <= 32'd0;
            r_err    <= w_misaligned;
        end else if (r_state == ACCESS) begin
            if (r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end else begin
                r_rdata <= r_rw ? 32'd0 : w_load_ext;
                r_err   <= 1'b0;
            end
        end
    end

    // Strobe is decoded from the state register so an asserted reset drops it at once
    assign bus.mem_E      = w_done && r_rw;
    assign bus.mem_RW     = (r_state == ACCESS) && r_rw;
    assign bus.mem_A      = r_addr;
    assign bus.mem_DI     = r_wdata;
    assign bus.mem_Size   = r_size;
    assign bus.req_ready  = (r_state == IDLE);
    assign bus.resp_valid = (r_state == RESP);
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;
endmodule
